// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and helpers for the serial pattern detector
package seq_det_pkg;

    localparam int             DEF_LEN     = 3;
    localparam logic [2:0]     DEF_PATTERN = 3'b101;
    localparam int             DEF_CNT_W   = 8;

    // All-ones value of a w-bit counter, returned zero-extended to 32 bits.
    function automatic logic [31:0] sat_value(input int w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear priority and saturation flag
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX = W'(sat_value(W));

    logic [W-1:0] cnt_nxt;

    // Clear wins but still records a coincident increment; otherwise count up and stick at all-ones.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = inc ? W'(1) : '0;
        end else if (inc && (cnt != MAX)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Register the count; sat looks at the next value so it rises together with cnt hitting all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= (cnt_nxt == MAX);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-pattern detector with match counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int             FW   = $clog2(LEN);
    localparam logic [FW-1:0]  FULL = FW'(LEN - 1);

    logic [LEN-2:0] window;
    logic [FW-1:0]  fill;
    logic [LEN-1:0] cand;
    logic           match;

    // The incoming bit completes a LEN-bit candidate; only trust it once the window holds LEN-1 real bits.
    always_comb begin
        cand  = {window, in};
        match = in_valid && (fill == FULL) && (cand == PATTERN);
    end

    // Shift the window on valid bits; in non-overlap mode a match discards the bits it consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window <= '0;
            fill   <= '0;
            det    <= 1'b0;
        end else begin
            det <= match;
            if (in_valid) begin
                window <= cand[LEN-2:0];
                if (match && !OVERLAP) begin
                    fill <= '0;
                end else if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param over four parameter sets
module tb_seq_detector_param;

    localparam int L0 = 3, P0 = 5, O0 = 1, C0 = 8;
    localparam int L1 = 3, P1 = 5, O1 = 0, C1 = 2;
    localparam int L2 = 3, P2 = 0, O2 = 1, C2 = 2;
    localparam int L3 = 2, P3 = 2, O3 = 0, C3 = 3;

    int plen [4] = '{L0, L1, L2, L3};
    int ppat [4] = '{P0, P1, P2, P3};
    int povl [4] = '{O0, O1, O2, O3};
    int pcw  [4] = '{C0, C1, C2, C3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic vld = 1'b0;
    logic clr = 1'b0;

    logic det0, det1, det2, det3;
    logic sat0, sat1, sat2, sat3;
    logic [C0-1:0] cnt0;
    logic [C1-1:0] cnt1;
    logic [C2-1:0] cnt2;
    logic [C3-1:0] cnt3;

    always #5 clk = ~clk;

    seq_detector_param #(.LEN(L0), .PATTERN(L0'(P0)), .OVERLAP(O0[0]), .CNT_W(C0)) u0 (
        .clk(clk), .rst(rst_n), .in(din), .in_valid(vld), .clr_cnt(clr),
        .det(det0), .match_cnt(cnt0), .cnt_sat(sat0));
    seq_detector_param #(.LEN(L1), .PATTERN(L1'(P1)), .OVERLAP(O1[0]), .CNT_W(C1)) u1 (
        .clk(clk), .rst(rst_n), .in(din), .in_valid(vld), .clr_cnt(clr),
        .det(det1), .match_cnt(cnt1), .cnt_sat(sat1));
    seq_detector_param #(.LEN(L2), .PATTERN(L2'(P2)), .OVERLAP(O2[0]), .CNT_W(C2)) u2 (
        .clk(clk), .rst(rst_n), .in(din), .in_valid(vld), .clr_cnt(clr),
        .det(det2), .match_cnt(cnt2), .cnt_sat(sat2));
    seq_detector_param #(.LEN(L3), .PATTERN(L3'(P3)), .OVERLAP(O3[0]), .CNT_W(C3)) u3 (
        .clk(clk), .rst(rst_n), .in(din), .in_valid(vld), .clr_cnt(clr),
        .det(det3), .match_cnt(cnt3), .cnt_sat(sat3));

    typedef struct packed {
        logic [3:0]       det;
        logic [3:0]       sat;
        logic [3:0][31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    // Reference model: history of valid bits since reset (or since the last non-overlapping match).
    bit  hist [4][$];
    int  mcnt [4];

    task automatic model_step(input bit i, input bit v, input bit c, input bit r, output exp_t e);
        for (int k = 0; k < 4; k++) begin
            int  maxc;
            bit  m;
            int  val;
            maxc = (1 << pcw[k]) - 1;
            m = 1'b0;
            if (!r) begin
                hist[k].delete();
                mcnt[k] = 0;
            end else begin
                if (v) begin
                    hist[k].push_back(i);
                    if (hist[k].size() >= plen[k]) begin
                        val = 0;
                        for (int j = 0; j < plen[k]; j++)
                            val = (val << 1) | int'(hist[k][hist[k].size() - plen[k] + j]);
                        m = (val == ppat[k]);
                    end
                    if (m && povl[k] == 0) hist[k].delete();
                    while (hist[k].size() > 16) void'(hist[k].pop_front());
                end
                if (c) mcnt[k] = m ? 1 : 0;
                else if (m && mcnt[k] < maxc) mcnt[k] = mcnt[k] + 1;
            end
            e.det[k] = m;
            e.cnt[k] = mcnt[k];
            e.sat[k] = (mcnt[k] == maxc);
        end
    endtask

    task automatic cyc(input bit i, input bit v, input bit c, input bit r);
        exp_t e;
        @(negedge clk);
        din = i; vld = v; clr = c; rst_n = r;
        model_step(i, v, c, r, e);
        exp_q.push_back(e);
    endtask

    task automatic stream(input int n, input logic [15:0] bits);
        for (int j = n - 1; j >= 0; j--) cyc(bits[j], 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: after each rising edge compare every instance against the oldest expectation.
    initial begin
        logic [3:0]       a_det, a_sat;
        logic [3:0][31:0] a_cnt;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a_det = {det3, det2, det1, det0};
                a_sat = {sat3, sat2, sat1, sat0};
                a_cnt[0] = 32'(cnt0);
                a_cnt[1] = 32'(cnt1);
                a_cnt[2] = 32'(cnt2);
                a_cnt[3] = 32'(cnt3);
                for (int k = 0; k < 4; k++) begin
                    n_vec++;
                    if (a_det[k] !== e.det[k]) begin
                        n_bad++;
                        $display("FAIL u%0d det at %0t: got %b expected %b", k, $time, a_det[k], e.det[k]);
                    end
                    n_vec++;
                    if (a_cnt[k] !== e.cnt[k]) begin
                        n_bad++;
                        $display("FAIL u%0d match_cnt at %0t: got %0d expected %0d", k, $time, a_cnt[k], e.cnt[k]);
                    end
                    n_vec++;
                    if (a_sat[k] !== e.sat[k]) begin
                        n_bad++;
                        $display("FAIL u%0d cnt_sat at %0t: got %b expected %b", k, $time, a_sat[k], e.sat[k]);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized stream.
    initial begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        stream(12, 16'b0000_0011_0110_0110);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        stream(5, 16'b10101);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        stream(6, 16'b000000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc(j != 1, 1'b1, 1'b0, 1'b1);
            if (j < 2) repeat (3) cyc(1'($urandom), 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        stream(11, 16'b101_0101_0101);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        stream(2, 16'b10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        stream(3, 16'b101);
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(29) == 0),
                ($urandom_range(199) != 0));
        end
        repeat (2) @(posedge clk);
        #2;
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete, got 0 expected 1");
        $fatal(1);
    end

endmodule
